// File: rtl/signed_sub_pkg.sv
// signed_sub_pkg
//   Shared constants and arithmetic helpers for the signed subtractor pipeline.
//   - DEF_WIDTH : default operand/result width
//   - MAXW      : width of the internal signed container used by the helpers;
//                 operand widths up to MAXW-1 are supported
//   - smax/smin : signed range limits for a w-bit two's complement value
//   - sat_sub   : a - b with overflow detection, optionally clamped
package signed_sub_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int MAXW      = 32;

  typedef logic signed [MAXW-1:0] word_t;

  function automatic word_t smax(input int w);
    return (word_t'(1) <<< (w - 1)) - word_t'(1);
  endfunction

  function automatic word_t smin(input int w);
    return -(word_t'(1) <<< (w - 1));
  endfunction

  // Operands arrive sign-extended from w bits into word_t, so the difference
  // fits without wrapping as long as w < MAXW. Result is {ovf, value}; the
  // caller keeps the low w bits of value, which is the modulo result when
  // no clamping is applied.
  function automatic logic [MAXW:0] sat_sub(input word_t a, input word_t b,
                                            input int w, input logic sat);
    word_t d;
    word_t r;
    logic  hi;
    logic  lo;
    d  = a - b;
    hi = (d > smax(w));
    lo = (d < smin(w));
    r  = d;
    if (sat && hi) r = smax(w);
    if (sat && lo) r = smin(w);
    return {hi | lo, r};
  endfunction

endpackage

// File: rtl/signed_sub_pipe_slice.sv
// pipe_slice
//   One valid/ready register stage with a parameterised payload.
//   The stage can load whenever it is empty or its content leaves this cycle,
//   so a full chain of slices sustains one transfer per clock.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_data             payload to capture
//   out_valid/out_ready downstream handshake
//   out_data            registered payload, held while out_valid && !out_ready
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/signed_sub_pipe.sv
// signed_sub_pipe
//   Two-stage pipelined signed subtractor, diff = in_a - in_b, with
//   valid/ready flow control. S1 registers the operand pair, S2 registers
//   the (optionally saturated) difference. Full throughput without
//   backpressure, at most two pairs in flight.
// Parameters
//   WIDTH  operand/result width, 2 <= WIDTH < signed_sub_pkg::MAXW
//   SAT    1 = clamp to the signed range on overflow, 0 = wrap
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready combinational from out_ready)
//   in_a, in_b            signed minuend / subtrahend
//   out_valid/out_ready   result handshake
//   diff                  signed result
//   ovf, ovf_cnt          overflow flag and saturating count of overflowed
//                         results transferred; present only when the
//                         SIGNED_SUB_OVF_EN macro is defined
module signed_sub_pipe
  import signed_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff
`ifdef SIGNED_SUB_OVF_EN
  ,
  output logic             ovf,
  output logic [7:0]       ovf_cnt
`endif
);

`ifdef SIGNED_SUB_OVF_EN
  localparam int S2W = WIDTH + 1;
`else
  localparam int S2W = WIDTH;
`endif

  logic                 s1_valid;
  logic                 s2_in_ready;
  logic [2*WIDTH-1:0]   s1_data;
  logic [MAXW:0]        sub_res;
  logic [S2W-1:0]       s2_in;
  logic [S2W-1:0]       s2_q;
  logic                 unused_res_bits;

  pipe_slice #(.W(2*WIDTH)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_a, in_b}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign sub_res = sat_sub(word_t'($signed(s1_data[2*WIDTH-1:WIDTH])),
                           word_t'($signed(s1_data[WIDTH-1:0])),
                           WIDTH, (SAT != 0));

`ifdef SIGNED_SUB_OVF_EN
  assign s2_in           = {sub_res[MAXW], sub_res[WIDTH-1:0]};
  assign unused_res_bits = ^sub_res[MAXW-1:WIDTH];
`else
  // Saturation still applies; only the flag itself is dropped.
  assign s2_in           = sub_res[WIDTH-1:0];
  assign unused_res_bits = ^sub_res[MAXW:WIDTH];
`endif

  pipe_slice #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign diff = s2_q[WIDTH-1:0];

`ifdef SIGNED_SUB_OVF_EN
  assign ovf = s2_q[WIDTH];

  // Counted on the output transfer only, so a result held under
  // backpressure is counted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'd0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_signed_sub_pipe.sv
module tb_signed_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_ready_w;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_valid_w;
  logic       out_ready;
  logic [7:0] diff;
  logic [7:0] diff_w;
`ifdef SIGNED_SUB_OVF_EN
  logic       ovf;
  logic       ovf_w;
  logic [7:0] ovf_cnt;
  logic [7:0] ovf_cnt_w;
`endif

  int checks   = 0;
  int failures = 0;

  signed_sub_pipe #(.WIDTH(8), .SAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
`ifdef SIGNED_SUB_OVF_EN
    ,
    .ovf       (ovf),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  signed_sub_pipe #(.WIDTH(8), .SAT(0)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .diff      (diff_w)
`ifdef SIGNED_SUB_OVF_EN
    ,
    .ovf       (ovf_w),
    .ovf_cnt   (ovf_cnt_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair for exactly one edge; caller guarantees in_ready.
  task automatic send(input int a, input int b);
    in_valid = 1'b1;
    in_a     = a[7:0];
    in_b     = b[7:0];
    #1;
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b1;

    // reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
`ifdef SIGNED_SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // basic: -5 - 3 = -8, visible two cycles after the accept cycle
    send(-5, 3);
    chk("t1_latency_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_diff", {24'd0, diff}, 32'h000000F8);
    chk("t1_diff_wrap", {24'd0, diff_w}, 32'h000000F8);
`ifdef SIGNED_SUB_OVF_EN
    chk("t1_ovf", {31'd0, ovf}, 32'd0);
`endif
    tick();
    chk("t1_drained", {31'd0, out_valid}, 32'd0);

    // overflow: 100 - (-100) = 200, -128 - 1 = -129
    send(100, -100);
    tick();
    chk("t2a_diff_sat", {24'd0, diff}, 32'h0000007F);
    chk("t2a_diff_wrap", {24'd0, diff_w}, 32'h000000C8);
`ifdef SIGNED_SUB_OVF_EN
    chk("t2a_ovf_sat", {31'd0, ovf}, 32'd1);
    chk("t2a_ovf_wrap", {31'd0, ovf_w}, 32'd1);
`endif
    send(-128, 1);
    tick();
    chk("t2b_diff_sat", {24'd0, diff}, 32'h00000080);
    chk("t2b_diff_wrap", {24'd0, diff_w}, 32'h0000007F);
`ifdef SIGNED_SUB_OVF_EN
    chk("t2b_ovf_sat", {31'd0, ovf}, 32'd1);
    chk("t2b_ovf_wrap", {31'd0, ovf_w}, 32'd1);
`endif
    tick();

    // backpressure: three pairs offered back-to-back, only two fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 8'd10; in_b = 8'd1;
    #1;
    chk("t3_rdy0", {31'd0, in_ready}, 32'd1);
    tick();
    in_a = 8'd20; in_b = 8'd2;
    #1;
    chk("t3_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    in_a = 8'd30; in_b = 8'd3;
    #1;
    chk("t3_rdy_drop", {31'd0, in_ready}, 32'd0);
    chk("t3_wrap_rdy_drop", {31'd0, in_ready_w}, 32'd0);
    chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_hold_diff", {24'd0, diff}, 32'd9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stall_rdy", {31'd0, in_ready}, 32'd0);
      chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_stall_diff", {24'd0, diff}, 32'd9);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_rdy_comb", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_out2_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out2", {24'd0, diff}, 32'd18);
    tick();
    chk("t3_out3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out3", {24'd0, diff}, 32'd27);
    tick();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // throughput: (i, -i) every cycle, results 2i on consecutive cycles
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        in_valid = 1'b1;
        in_a = 8'(k);
        in_b = 8'(-k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t4_out_valid", {31'd0, out_valid}, (k >= 1 && k <= 10) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 10) chk("t4_diff", {24'd0, diff}, 32'(2 * (k - 1)));
    end
    in_valid = 1'b0;

    // reset mid-stream with both stages occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 8'd5; in_b = 8'd1;
    tick();
    in_a = 8'd6; in_b = 8'd1;
    tick();
    in_valid = 1'b0;
    chk("t5_full_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_full_rdy", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_async_diff", {24'd0, diff}, 32'd0);
`ifdef SIGNED_SUB_OVF_EN
    chk("t5_async_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
    end

`ifdef SIGNED_SUB_OVF_EN
    // overflowing result held under backpressure counts once
    out_ready = 1'b0;
    send(100, -100);
    tick();
    chk("t6_held_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_held_ovf", {31'd0, ovf}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_held_cnt", {24'd0, ovf_cnt}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t6_cnt_once", {24'd0, ovf_cnt}, 32'd1);
    // 300 more overflowing transfers saturate the counter
    in_valid = 1'b1;
    in_a = 8'h80; in_b = 8'd1;
    for (int k = 0; k < 300; k++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_cnt_sat", {24'd0, ovf_cnt}, 32'd255);
    chk("t6_cnt_sat_wrap", {24'd0, ovf_cnt_w}, 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
